decode_hazard_scoreboard: RTL and testbench
===========================================

# decode_hazard_scoreboard

Register-dependency scoreboard and issue controller for the decode stage. It tracks outstanding register-file writes per architectural register. When a decoding instruction reads a register with a pending write, or targets a register whose pending-write counter is saturated, it holds the instruction in decode. It sits beside the decode-stage register file: the decode side presents sources and the muxed write destination, and writeback reports retiring writes.

## Interface
Parameters:
- `CNT_W`, default 2: width of each per-register pending-write counter; max outstanding writes per register = 2^CNT_W − 1.
- `STALL_CNT_W`, default 16: width of the stall-cycle performance counter.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `id_valid` in 1: decode holds a valid instruction.
- `id_rs` in 5: first source register address.
- `id_rt` in 5: second source register address.
- `id_uses_rs` in 1: instruction reads `id_rs`.
- `id_uses_rt` in 1: instruction reads `id_rt`.
- `id_reg_write` in 1: instruction will write the register file.
- `id_dst` in 5: write destination, already selected between rt and rd.
- `wb_reg_write` in 1: writeback commits a register write this cycle.
- `wb_dst` in 5: writeback destination.
- `issue_ready` out 1: decode may issue this cycle. Combinational.
- `issue` out 1: `id_valid & issue_ready`. Combinational.
- `hazard_rs` out 1: stall cause is the `id_rs` dependency.
- `hazard_rt` out 1: stall cause is the `id_rt` dependency.
- `hazard_dst` out 1: stall cause is `id_dst` counter saturation.
- `pending_mask` out 32: bit i = 1 when counter i ≠ 0. Registered.
- `stall_count` out STALL_CNT_W: saturating count of stalled cycles.
- `underflow_err` out 1: sticky flag, set when a retire hits a zero counter.

## Operation
- State: 32 counters `cnt[i]`, `stall_count`, `underflow_err`. Counter 0 is hard-wired to 0.
- Hazard terms, evaluated combinationally from the current state:
  - `hazard_rs = id_valid & id_uses_rs & (id_rs≠0) & (cnt[id_rs]≠0)`
  - `hazard_rt` is the same term using `id_rt`.
  - `hazard_dst = id_valid & id_reg_write & (id_dst≠0) & (cnt[id_dst]==MAX)`
- `issue_ready = ~(hazard_rs | hazard_rt | hazard_dst)`. When `id_valid=0`, `issue_ready=1` and `issue=0`.
- Increment: on `issue & id_reg_write & id_dst≠0`, `cnt[id_dst]` increments.
- Decrement: on `wb_reg_write & wb_dst≠0`:
  - If `cnt[wb_dst]≠0`, it decrements.
  - If `cnt[wb_dst]==0`, the counter is unchanged and `underflow_err` is set.
- Same register incremented and decremented in one cycle: net unchanged. Not an underflow, even when the counter is 0.
- No retire bypass. A source whose only pending write retires this cycle still stalls this cycle and issues the next cycle, because the register-file write lands at this edge.
- `stall_count` increments on each cycle with `id_valid & ~issue_ready`. It saturates at all-ones.
- `underflow_err` clears only on reset.

## Timing
- Reset (`reset`=0, asynchronous): all `cnt`=0, `pending_mask`=0, `stall_count`=0, `underflow_err`=0. Combinational outputs follow from that state (`issue_ready`=1).
- Reset asserted mid-operation discards all pending state immediately. No retire is expected for writes issued before reset; any such retire raises `underflow_err`.
- Issue-to-visible latency: an issue at edge N makes `pending_mask` and hazards reflect the new count from cycle N+1.
- Retire-to-release latency: a retire at edge N releases a dependent instruction, which issues in cycle N+1 and no earlier.
- Decode must hold `id_*` stable while `issue_ready=0`. The block does not latch the instruction.

## Test plan
- Reset then idle: `reset` low for 2 cycles, then high, `id_valid=0` → `pending_mask=0`, `issue_ready=1`, `stall_count=0`.
- RAW stall:
  - Stimulus: issue a write with `id_dst=5`, then the next cycle present `id_rs=5, id_uses_rs=1`; assert `wb_reg_write=1, wb_dst=5` on the 3rd cycle.
  - Response: `hazard_rs=1` for 3 cycles; issue occurs in the cycle after the retire edge; `stall_count=3`.
- Register 0: `id_dst=0` write issued, then `id_rs=0` read → no stall, `pending_mask=0`.
- Saturation (CNT_W=2): issue 3 writes to r7 with no retire, then a 4th → `hazard_dst=1`; one retire of r7 → 4th issues next cycle and `cnt[7]` returns to 3.
- Simultaneous issue and retire to r9 with `cnt[9]=1` → `cnt[9]` stays 1 and `underflow_err` stays 0. A retire to r10 with `cnt[10]=0` → `underflow_err=1` and stays 1 until reset.
- Reset mid-operation: `pending_mask=0x0000_0060`, assert `reset` asynchronously between edges → `pending_mask=0` immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_hazard_scoreboard.sv
// decode_hazard_scoreboard
//   Register-dependency scoreboard for the decode stage. Keeps a pending-write
//   counter per architectural register and holds the decoding instruction when
//   it reads a register with an outstanding write, or when its destination
//   counter is already saturated.
//
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   id_valid            : decode holds a valid instruction
//   id_rs / id_rt       : source register addresses
//   id_uses_rs/rt       : instruction actually reads the matching source
//   id_reg_write/id_dst : instruction writes id_dst
//   wb_reg_write/wb_dst : writeback retires a write to wb_dst this cycle
//   issue_ready, issue  : combinational issue permission / handshake
//   hazard_rs/rt/dst    : combinational stall causes
//   pending_mask        : bit i set while register i has outstanding writes
//   stall_count         : saturating count of stalled cycles
//   underflow_err       : sticky, a retire hit a zero counter
module decode_hazard_scoreboard #(
  parameter int unsigned CNT_W       = 2,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic                   id_reg_write,
  input  logic [4:0]             id_dst,
  input  logic                   wb_reg_write,
  input  logic [4:0]             wb_dst,
  output logic                   issue_ready,
  output logic                   issue,
  output logic                   hazard_rs,
  output logic                   hazard_rt,
  output logic                   hazard_dst,
  output logic [31:0]            pending_mask,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   underflow_err
);

  localparam logic [CNT_W-1:0]       CntZero  = '0;
  localparam logic [CNT_W-1:0]       CntOne   = CntZero + 1'b1;
  localparam logic [CNT_W-1:0]       CntMax   = '1;
  localparam logic [STALL_CNT_W-1:0] StallOne = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_CNT_W-1:0] StallMax = '1;

  logic [CNT_W-1:0]       cnt_q [32];
  logic [CNT_W-1:0]       cnt_d [32];
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   underflow_q, underflow_d;
  logic                   inc_en, dec_en, stalled;

  // Hazards look only at registered counts: a retire this cycle does not bypass.
  always_comb begin
    hazard_rs  = id_valid & id_uses_rs & (id_rs != 5'd0) & (cnt_q[id_rs] != CntZero);
    hazard_rt  = id_valid & id_uses_rt & (id_rt != 5'd0) & (cnt_q[id_rt] != CntZero);
    hazard_dst = id_valid & id_reg_write & (id_dst != 5'd0) & (cnt_q[id_dst] == CntMax);
  end

  assign issue_ready = ~(hazard_rs | hazard_rt | hazard_dst);
  assign issue       = id_valid & issue_ready;
  assign stalled     = id_valid & ~issue_ready;
  assign inc_en      = issue & id_reg_write & (id_dst != 5'd0);
  assign dec_en      = wb_reg_write & (wb_dst != 5'd0);

  always_comb begin
    cnt_d       = cnt_q;
    underflow_d = underflow_q;
    // Issue and retire to the same register cancel, even from zero.
    if (!(inc_en && dec_en && (id_dst == wb_dst))) begin
      // Increment cannot wrap: hazard_dst blocks issue at CntMax.
      if (inc_en) cnt_d[id_dst] = cnt_q[id_dst] + CntOne;
      if (dec_en) begin
        if (cnt_q[wb_dst] == CntZero) underflow_d = 1'b1;
        else                          cnt_d[wb_dst] = cnt_q[wb_dst] - CntOne;
      end
    end
    cnt_d[0] = CntZero;
  end

  always_comb begin
    stall_d = stall_q;
    if (stalled && (stall_q != StallMax)) stall_d = stall_q + StallOne;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= CntZero;
      stall_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
      stall_q     <= stall_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 32; i++) pending_mask[i] = (cnt_q[i] != CntZero);
  end

  assign stall_count   = stall_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_decode_hazard_scoreboard.sv
// Self-checking bench for decode_hazard_scoreboard: directed scenarios followed
// by constrained-random traffic, all checked against an array-of-counts model.
module tb_decode_hazard_scoreboard;

  localparam int CNT_W       = 2;
  localparam int STALL_CNT_W = 16;
  localparam int MAXC        = (1 << CNT_W) - 1;
  localparam int STALL_MAX   = (1 << STALL_CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   id_valid = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0;
  logic                   id_reg_write = 1'b0, wb_reg_write = 1'b0;
  logic [4:0]             id_rs = '0, id_rt = '0, id_dst = '0, wb_dst = '0;
  logic                   issue_ready, issue, hazard_rs, hazard_rt, hazard_dst;
  logic [31:0]            pending_mask;
  logic [STALL_CNT_W-1:0] stall_count;
  logic                   underflow_err;

  decode_hazard_scoreboard #(.CNT_W(CNT_W), .STALL_CNT_W(STALL_CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_reg_write (id_reg_write),
    .id_dst       (id_dst),
    .wb_reg_write (wb_reg_write),
    .wb_dst       (wb_dst),
    .issue_ready  (issue_ready),
    .issue        (issue),
    .hazard_rs    (hazard_rs),
    .hazard_rt    (hazard_rt),
    .hazard_dst   (hazard_dst),
    .pending_mask (pending_mask),
    .stall_count  (stall_count),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  // Reference model: outstanding writes per register, stall total, sticky error.
  int cnt_m [32];
  int stall_m;
  bit uf_m;

  int n_checks = 0;
  int n_fail   = 0;

  // DUT combinational outputs sampled in the most recent cycle.
  logic obs_hrs, obs_hrt, obs_hd, obs_issue;
  bit   m_stalled;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) cnt_m[i] = 0;
    stall_m = 0;
    uf_m    = 1'b0;
  endtask

  task automatic drv(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                     input bit rw, input int dst, input bit wbw, input int wbd);
    id_valid     = v;
    id_rs        = 5'(rs);
    id_uses_rs   = urs;
    id_rt        = 5'(rt);
    id_uses_rt   = urt;
    id_reg_write = rw;
    id_dst       = 5'(dst);
    wb_reg_write = wbw;
    wb_dst       = 5'(wbd);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called at a falling edge with inputs already driven: checks every output
  // against the model, crosses one rising edge, then advances the model.
  task automatic cycle();
    bit hrs, hrt, hd, rdy, iss, inc, dec;
    logic [31:0] pm;
    #1;
    hrs = id_valid && id_uses_rs && (id_rs != 0) && (cnt_m[id_rs] != 0);
    hrt = id_valid && id_uses_rt && (id_rt != 0) && (cnt_m[id_rt] != 0);
    hd  = id_valid && id_reg_write && (id_dst != 0) && (cnt_m[id_dst] == MAXC);
    rdy = !(hrs || hrt || hd);
    iss = id_valid && rdy;
    pm  = '0;
    for (int i = 1; i < 32; i++) if (cnt_m[i] != 0) pm[i] = 1'b1;
    check_eq("hazard_rs", 32'(hazard_rs), 32'(hrs));
    check_eq("hazard_rt", 32'(hazard_rt), 32'(hrt));
    check_eq("hazard_dst", 32'(hazard_dst), 32'(hd));
    check_eq("issue_ready", 32'(issue_ready), 32'(rdy));
    check_eq("issue", 32'(issue), 32'(iss));
    check_eq("pending_mask", pending_mask, pm);
    check_eq("stall_count", 32'(stall_count), 32'(stall_m));
    check_eq("underflow_err", 32'(underflow_err), 32'(uf_m));
    obs_hrs   = hazard_rs;
    obs_hrt   = hazard_rt;
    obs_hd    = hazard_dst;
    obs_issue = issue;
    m_stalled = id_valid && !rdy;
    @(posedge clk);
    if (id_valid && !rdy && stall_m < STALL_MAX) stall_m++;
    inc = iss && id_reg_write && (id_dst != 0);
    dec = wb_reg_write && (wb_dst != 0);
    if (!(inc && dec && id_dst == wb_dst)) begin
      if (inc) cnt_m[id_dst]++;
      if (dec) begin
        if (cnt_m[wb_dst] == 0) uf_m = 1'b1;
        else cnt_m[wb_dst]--;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check_eq("rst_pending", pending_mask, 32'h0);
    reset = 1'b1;
  endtask

  initial begin
    model_clear();
    idle();

    // Reset then idle.
    do_reset();
    cycle();
    check_eq("idle_ready", 32'(issue_ready), 32'd1);
    check_eq("idle_stall", 32'(stall_count), 32'd0);

    // RAW stall on r5, retire in the third stalled cycle.
    drv(1, 0, 0, 0, 0, 1, 5, 0, 0); cycle();
    check_eq("raw_first_issue", 32'(obs_issue), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drv(1, 5, 1, 0, 0, 0, 0, (k == 2), 5); cycle();
      check_eq("raw_hazard_rs", 32'(obs_hrs), 32'd1);
    end
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0); cycle();
    check_eq("raw_release_issue", 32'(obs_issue), 32'd1);
    idle(); cycle();
    check_eq("raw_stall_count", 32'(stall_count), 32'd3);

    // Register 0 never becomes pending.
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 0, 0, 0); cycle();
    drv(1, 0, 1, 0, 1, 0, 0, 0, 0); cycle();
    check_eq("r0_no_stall", 32'(obs_issue), 32'd1);
    check_eq("r0_mask", pending_mask, 32'h0);

    // Saturation of r7.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drv(1, 0, 0, 0, 0, 1, 7, 0, 0); cycle();
      check_eq("sat_fill_issue", 32'(obs_issue), 32'd1);
    end
    drv(1, 0, 0, 0, 0, 1, 7, 0, 0); cycle();
    check_eq("sat_hazard_dst", 32'(obs_hd), 32'd1);
    drv(1, 0, 0, 0, 0, 1, 7, 1, 7); cycle();
    check_eq("sat_hold_on_retire", 32'(obs_hd), 32'd1);
    drv(1, 0, 0, 0, 0, 1, 7, 0, 0); cycle();
    check_eq("sat_fourth_issue", 32'(obs_issue), 32'd1);
    drv(1, 0, 0, 0, 0, 1, 7, 0, 0); cycle();
    check_eq("sat_back_to_max", 32'(obs_hd), 32'd1);

    // Simultaneous issue/retire on r9, then a true underflow on r10.
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 9, 0, 0); cycle();
    drv(1, 0, 0, 0, 0, 1, 9, 1, 9); cycle();
    idle(); cycle();
    check_eq("sim_mask9", 32'(pending_mask[9]), 32'd1);
    check_eq("sim_no_uf", 32'(underflow_err), 32'd0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 9); cycle();
    idle(); cycle();
    check_eq("sim_cnt9_was_one", 32'(pending_mask[9]), 32'd0);
    check_eq("sim_still_no_uf", 32'(underflow_err), 32'd0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 10); cycle();
    idle();
    repeat (3) cycle();
    check_eq("uf_sticky", 32'(underflow_err), 32'd1);

    // Asynchronous reset mid-operation.
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 5, 0, 0); cycle();
    drv(1, 0, 0, 0, 0, 1, 6, 0, 0); cycle();
    idle();
    check_eq("mid_mask_before", pending_mask, 32'h0000_0060);
    #2 reset = 1'b0;
    #1 check_eq("mid_async_mask", pending_mask, 32'h0);
    check_eq("mid_async_ready", 32'(issue_ready), 32'd1);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    cycle();

    // Constrained-random traffic over a small register window.
    do_reset();
    m_stalled = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      int wbd;
      bit wbw;
      if (!m_stalled) begin
        drv($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 7), 0, 0);
      end
      wbw = ($urandom_range(0, 2) == 0);
      wbd = $urandom_range(0, 7);
      if ($urandom_range(0, 9) != 0) begin
        for (int t = 0; t < 8; t++) begin
          int r = $urandom_range(1, 7);
          if (cnt_m[r] != 0) begin
            wbd = r;
            break;
          end
        end
      end
      wb_reg_write = wbw;
      wb_dst       = 5'(wbd);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
